// File: rtl/dp_seq_ctrl_pkg.sv
// ============================================================================
// dp_seq_pkg : shared types and defaults for the scheduled dataflow sequencer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package dp_seq_pkg;

    localparam int DP_DATAWIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_D   = 3'd1,
        S_E   = 3'd2,
        S_F   = 3'd3,
        S_SEL = 3'd4,
        S_SH  = 3'd5
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/dp_seq_ctrl_if.sv
// ============================================================================
// dp_seq_ctrl_if : request/operand and result bundle of the sequencer
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface dp_seq_ctrl_if #(
    parameter int DATAWIDTH = 32
);
    logic                 start;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
    logic                 busy;
    logic                 done;
    logic [DATAWIDTH-1:0] x;
    logic [DATAWIDTH-1:0] z;
    logic                 dlte;
    logic                 deqe;

    modport master (
        output start, a, b, c,
        input  busy, done, x, z, dlte, deqe
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, x, z, dlte, deqe
    );
endinterface

`default_nettype wire

// File: rtl/dp_seq_ctrl_addsub.sv
// ============================================================================
// dp_addsub : combinational add/subtract unit shared by every schedule step
// Revision  : 1.0
// ============================================================================
`default_nettype none

module dp_addsub
    import dp_seq_pkg::*;
#(
    parameter int DATAWIDTH = DP_DATAWIDTH
) (
    input  alu_op_e              op_i,
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    output logic [DATAWIDTH-1:0] y_o
);

    assign y_o = (op_i == OP_SUB) ? (a_i - b_i) : (a_i + b_i);

endmodule

`default_nettype wire

// File: rtl/dp_seq_ctrl.sv
// ============================================================================
// dp_seq_ctrl : computes d/e/f, compare, select and shift over six states
//               using a single shared adder/subtractor
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dp_seq_ctrl
    import dp_seq_pkg::*;
#(
    parameter int DATAWIDTH = DP_DATAWIDTH
) (
    input  logic         Clk,
    input  logic         Rst,
    dp_seq_ctrl_if.slave bus
);

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [DATAWIDTH-1:0] d_q, d_d, e_q, e_d, f_q, f_d;
    logic [DATAWIDTH-1:0] g_q, g_d, h_q, h_d;
    logic [DATAWIDTH-1:0] x_q, x_d, z_q, z_d;
    logic                 dlte_q, dlte_d, deqe_q, deqe_d, done_q, done_d;

    alu_op_e              alu_op;
    logic [DATAWIDTH-1:0] alu_b, alu_y;
    logic                 w_lt, w_eq;
    logic [DATAWIDTH-1:0] w_g, w_h;

    // Operand A is always ra; only the B-side mux and the op change per state.
    dp_addsub #(.DATAWIDTH(DATAWIDTH)) u_addsub (
        .op_i (alu_op),
        .a_i  (ra_q),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    assign w_lt = (d_q < e_q);
    assign w_eq = (d_q == e_q);
    assign w_g  = w_lt ? e_q : d_q;
    assign w_h  = w_eq ? f_q : w_g;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        d_d     = d_q;
        e_d     = e_q;
        f_d     = f_q;
        g_d     = g_q;
        h_d     = h_q;
        x_d     = x_q;
        z_d     = z_q;
        dlte_d  = dlte_q;
        deqe_d  = deqe_q;
        done_d  = 1'b0;
        alu_op  = OP_ADD;
        alu_b   = rb_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    rc_d    = bus.c;
                    state_d = S_D;
                end
            end
            S_D: begin
                d_d     = alu_y;
                state_d = S_E;
            end
            S_E: begin
                alu_b   = rc_q;
                e_d     = alu_y;
                state_d = S_F;
            end
            S_F: begin
                alu_op  = OP_SUB;
                f_d     = alu_y;
                state_d = S_SEL;
            end
            S_SEL: begin
                g_d     = w_g;
                h_d     = w_h;
                dlte_d  = w_lt;
                deqe_d  = w_eq;
                state_d = S_SH;
            end
            S_SH: begin
                x_d     = g_q << dlte_q;
                z_d     = h_q >> deqe_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            z_q     <= '0;
            dlte_q  <= 1'b0;
            deqe_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            d_q     <= d_d;
            e_q     <= e_d;
            f_q     <= f_d;
            g_q     <= g_d;
            h_q     <= h_d;
            x_q     <= x_d;
            z_q     <= z_d;
            dlte_q  <= dlte_d;
            deqe_q  <= deqe_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.x    = x_q;
    assign bus.z    = z_q;
    assign bus.dlte = dlte_q;
    assign bus.deqe = deqe_q;

endmodule

`default_nettype wire

// File: tb/tb_dp_seq_ctrl.sv
// ============================================================================
// tb_dp_seq_ctrl : directed stimulus, per-cycle reference model comparison
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_dp_seq_ctrl;

    logic Clk;
    logic Rst;
    int   checks = 0;
    int   errors = 0;

    dp_seq_ctrl_if #(.DATAWIDTH(32)) bus ();

    dp_seq_ctrl #(.DATAWIDTH(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
        end
    endtask

    // Whole dataflow evaluated directly from the operand values.
    task automatic calc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        output logic [31:0] ox, output logic [31:0] oz,
                        output logic olt, output logic oeq);
        logic [31:0] d, e, f, g, h;
        d   = a + b;
        e   = a + c;
        f   = a - b;
        olt = d < e;
        oeq = d == e;
        g   = olt ? e : d;
        h   = oeq ? f : g;
        ox  = olt ? g * 32'd2 : g;
        oz  = oeq ? h / 32'd2 : h;
    endtask

    // Reference model: a transaction is a countdown from acceptance to done.
    int          m_cnt = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_px, m_pz, m_x, m_z;
    logic        m_plt, m_peq, m_lt, m_eq, m_done;

    always @(posedge Clk) begin
        if (!Rst) begin
            m_cnt = 0; m_x = '0; m_z = '0; m_lt = 1'b0; m_eq = 1'b0; m_done = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (bus.start) begin
                    calc(bus.a, bus.b, bus.c, m_px, m_pz, m_plt, m_peq);
                    m_cnt = 5;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 1) begin
                    m_lt = m_plt;
                    m_eq = m_peq;
                end
                if (m_cnt == 0) begin
                    m_x    = m_px;
                    m_z    = m_pz;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, m_cnt != 0});
            chk("done", {31'd0, bus.done}, {31'd0, m_done});
            chk("x",    bus.x, m_x);
            chk("z",    bus.z, m_z);
            chk("dlte", {31'd0, bus.dlte}, {31'd0, m_lt});
            chk("deqe", {31'd0, bus.deqe}, {31'd0, m_eq});
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] ex, input logic [31:0] ez,
                         input logic elt, input logic eeq, input string name);
        int k;
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.c = c;
        @(negedge Clk);
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k < 12) begin
            @(negedge Clk);
            k++;
        end
        chk({name, "_latency"}, k, 32'd6);
        chk({name, "_x"}, bus.x, ex);
        chk({name, "_z"}, bus.z, ez);
        chk({name, "_dlte"}, {31'd0, bus.dlte}, {31'd0, elt});
        chk({name, "_deqe"}, {31'd0, bus.deqe}, {31'd0, eeq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    initial begin
        int k;
        int extra;
        Rst = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
        idle(3);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_x", bus.x, 32'd0);
        chk("rst_z", bus.z, 32'd0);
        Rst = 1'b1;
        idle(2);

        // busy must be high exactly for the 5 cycles between acceptance and done
        bus.start = 1'b1; bus.a = 32'd10; bus.b = 32'd3; bus.c = 32'd5;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            bus.start = 1'b0;
            if (bus.busy) k++;
        end
        chk("t1_busy_cycles", k, 32'd5);
        @(negedge Clk);
        chk("t1_done", {31'd0, bus.done}, 32'd1);
        chk("t1_x", bus.x, 32'd30);
        chk("t1_z", bus.z, 32'd15);
        chk("t1_dlte", {31'd0, bus.dlte}, 32'd1);
        idle(2);

        do_op(32'd4, 32'd6, 32'd6, 32'd10, 32'h7FFF_FFFF, 1'b0, 1'b1, "eq");
        idle(1);
        do_op(32'd1, 32'd9, 32'd2, 32'd10, 32'd10, 1'b0, 1'b0, "gt");
        idle(2);

        // Wrap case with start hammered (and operands scrambled) while busy
        bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1; bus.c = 32'd2;
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            bus.a = $urandom; bus.b = $urandom; bus.c = $urandom; bus.start = 1'b1;
        end
        @(negedge Clk);
        bus.start = 1'b0;
        chk("wrap_done", {31'd0, bus.done}, 32'd1);
        chk("wrap_x", bus.x, 32'd2);
        chk("wrap_z", bus.z, 32'd1);
        chk("wrap_dlte", {31'd0, bus.dlte}, 32'd1);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (bus.done || bus.busy) extra++;
        end
        chk("wrap_no_second_op", extra, 32'd0);

        // Back-to-back: second request issued in the done cycle
        do_op(32'd1, 32'd9, 32'd2, 32'd10, 32'd10, 1'b0, 1'b0, "b2b_first");
        do_op(32'd10, 32'd3, 32'd5, 32'd30, 32'd15, 1'b1, 1'b0, "b2b_second");
        idle(2);

        // Reset asserted while the sequencer is in S_F
        bus.start = 1'b1; bus.a = 32'd4; bus.b = 32'd6; bus.c = 32'd6;
        @(negedge Clk);
        bus.start = 1'b0;
        idle(2);
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_x", bus.x, 32'd0);
        chk("abort_z", bus.z, 32'd0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (bus.done) extra++;
        end
        chk("abort_no_done", extra, 32'd0);
        do_op(32'd10, 32'd3, 32'd5, 32'd30, 32'd15, 1'b1, 1'b0, "after_abort");
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
